// File: rtl/intr_dispatch_pkg.sv
// Shared types and constants for the interrupt dispatcher and its input qualifier.
package intr_dispatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_QUAL  = 3'd1,
        ST_REQ   = 3'd2,
        ST_CLEAR = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic [1:0] GRP_A    = 2'd0;
    localparam logic [1:0] GRP_B    = 2'd1;
    localparam logic [1:0] GRP_C    = 2'd2;
    localparam logic [3:0] MAX_CHAN = 4'd8;
    localparam int         VEC_W    = 6;

endpackage

// File: rtl/intr_qualify.sv
// Registers the encoder outputs, selects the highest-priority unmasked group and
// tracks how many consecutive identical samples the current candidate has shown.
module intr_qualify
    import intr_dispatch_pkg::*;
#(
    parameter int STABLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pa,
    input  logic             pb,
    input  logic             pc,
    input  logic [3:0]       chan,
    input  logic [2:0]       grp_mask,
    input  logic             idle,
    input  logic             qual,
    input  logic             err_clr,
    output logic             cand_vld,
    output logic             stable,
    output logic [VEC_W-1:0] vec,
    output logic             bad_chan
);

    logic             pa_r, pb_r, pc_r;
    logic [3:0]       chan_r;
    logic             grp_sel;
    logic [1:0]       grp;
    logic [VEC_W-1:0] cand_vec;
    logic [3:0]       cnt;
    logic [4:0]       cnt_next;

    always_comb begin
        grp_sel = 1'b1;
        grp     = GRP_A;
        if (pa_r && !grp_mask[0]) begin
            grp = GRP_A;
        end else if (pb_r && !grp_mask[1]) begin
            grp = GRP_B;
        end else if (pc_r && !grp_mask[2]) begin
            grp = GRP_C;
        end else begin
            grp_sel = 1'b0;
        end
    end

    assign cand_vld = grp_sel && (chan_r <= MAX_CHAN);
    assign cand_vec = {grp, chan_r};
    assign cnt_next = {1'b0, cnt} + 5'd1;

    // From IDLE the first sample is already the whole qualification when STABLE_CYC is 1.
    assign stable = cand_vld &&
                    (idle ? (STABLE_CYC == 1)
                          : (qual && cand_vec == vec && cnt_next == 5'(STABLE_CYC)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pa_r     <= 1'b0;
            pb_r     <= 1'b0;
            pc_r     <= 1'b0;
            chan_r   <= 4'd0;
            vec      <= '0;
            cnt      <= 4'd0;
            bad_chan <= 1'b0;
        end else begin
            pa_r   <= pa;
            pb_r   <= pb;
            pc_r   <= pc;
            chan_r <= chan;
            if (grp_sel && chan_r > MAX_CHAN) begin
                bad_chan <= 1'b1;
            end else if (err_clr) begin
                bad_chan <= 1'b0;
            end
            if (cand_vld && (idle || (qual && cand_vec != vec))) begin
                vec <= cand_vec;
                cnt <= 4'd1;
            end else if (cand_vld && qual) begin
                cnt <= cnt_next[3:0];
            end
        end
    end

endmodule

// File: rtl/intr_dispatch.sv
// Interrupt dispatcher: qualified vector -> CPU req/ack -> source clear valid/ready.
// Optional INTR_DISPATCH_STATS_EN adds dispatch and timeout counters.
// Handshakes: INT_REQ holds with a stable INT_VEC until INT_ACK is sampled high;
// CLR_VLD holds with stable CLR_GRP/CLR_CHAN until CLR_RDY is sampled high.
module intr_dispatch
    import intr_dispatch_pkg::*;
#(
    parameter int STABLE_CYC = 2,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 8
) (
    input  logic             CK,
    input  logic             RST_N,
    input  logic             PA,
    input  logic             PB,
    input  logic             PC,
    input  logic [3:0]       CHAN,
    input  logic [2:0]       GRP_MASK,
    output logic             INT_REQ,
    output logic [VEC_W-1:0] INT_VEC,
    input  logic             INT_ACK,
    output logic             CLR_VLD,
    output logic [1:0]       CLR_GRP,
    output logic [3:0]       CLR_CHAN,
    input  logic             CLR_RDY,
    output logic             TMO_ERR,
    output logic             BAD_CHAN,
    input  logic             ERR_CLR,
`ifdef INTR_DISPATCH_STATS_EN
    output logic [15:0]      DISP_CNT,
    output logic [15:0]      TMO_CNT,
`endif
    output state_t           STATE_DBG
);

    state_t           state, state_next;
    logic             cand_vld, stable;
    logic [VEC_W-1:0] vec;
    logic [CNT_W-1:0] tmo_cnt;
    logic             hold_cnt;
    logic             tmo_hit;
    logic             ack_acc;

    intr_qualify #(.STABLE_CYC(STABLE_CYC)) u_qualify (
        .clk      (CK),
        .rst_n    (RST_N),
        .pa       (PA),
        .pb       (PB),
        .pc       (PC),
        .chan     (CHAN),
        .grp_mask (GRP_MASK),
        .idle     (state == ST_IDLE),
        .qual     (state == ST_QUAL),
        .err_clr  (ERR_CLR),
        .cand_vld (cand_vld),
        .stable   (stable),
        .vec      (vec),
        .bad_chan (BAD_CHAN)
    );

    always_comb begin
        state_next = state;
        tmo_hit    = 1'b0;
        case (state)
            ST_IDLE:  if (cand_vld) state_next = stable ? ST_REQ : ST_QUAL;
            ST_QUAL: begin
                if (!cand_vld)   state_next = ST_IDLE;
                else if (stable) state_next = ST_REQ;
            end
            // Ack takes precedence over a timeout landing in the same cycle.
            ST_REQ: begin
                if (INT_ACK) begin
                    state_next = ST_CLEAR;
                end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                    tmo_hit    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR: if (CLR_RDY) state_next = ST_HOLD;
            ST_HOLD:  if (hold_cnt) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign ack_acc   = (state == ST_REQ) && INT_ACK;
    assign INT_REQ   = (state == ST_REQ);
    assign INT_VEC   = (state == ST_REQ) ? vec : '0;
    assign CLR_VLD   = (state == ST_CLEAR);
    assign CLR_GRP   = (state == ST_CLEAR) ? vec[5:4] : 2'd0;
    assign CLR_CHAN  = (state == ST_CLEAR) ? vec[3:0] : 4'd0;
    assign STATE_DBG = state;

    always_ff @(posedge CK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            tmo_cnt  <= '0;
            hold_cnt <= 1'b0;
            TMO_ERR  <= 1'b0;
        end else begin
            state    <= state_next;
            tmo_cnt  <= (state == ST_REQ) ? tmo_cnt + 1'b1 : '0;
            hold_cnt <= (state == ST_HOLD) ? ~hold_cnt : 1'b0;
            if (tmo_hit)      TMO_ERR <= 1'b1;
            else if (ERR_CLR) TMO_ERR <= 1'b0;
        end
    end

`ifdef INTR_DISPATCH_STATS_EN
    always_ff @(posedge CK) begin
        if (!RST_N || ERR_CLR) begin
            DISP_CNT <= 16'd0;
            TMO_CNT  <= 16'd0;
        end else begin
            if (ack_acc && DISP_CNT != 16'hFFFF) DISP_CNT <= DISP_CNT + 16'd1;
            if (tmo_hit && TMO_CNT != 16'hFFFF)  TMO_CNT  <= TMO_CNT + 16'd1;
        end
    end
`else
    logic unused_ack;
    assign unused_ack = ack_acc;
`endif

endmodule

// File: tb/tb_intr_dispatch.sv
// Directed bench for intr_dispatch (STABLE_CYC=2, TIMEOUT=4).
module tb_intr_dispatch;
    import intr_dispatch_pkg::*;

    logic        CK = 1'b0;
    logic        RST_N = 1'b0;
    logic        PA = 1'b0, PB = 1'b0, PC = 1'b0;
    logic [3:0]  CHAN = 4'd0;
    logic [2:0]  GRP_MASK = 3'd0;
    logic        INT_REQ;
    logic [5:0]  INT_VEC;
    logic        INT_ACK = 1'b0;
    logic        CLR_VLD;
    logic [1:0]  CLR_GRP;
    logic [3:0]  CLR_CHAN;
    logic        CLR_RDY = 1'b0;
    logic        TMO_ERR, BAD_CHAN;
    logic        ERR_CLR = 1'b0;
`ifdef INTR_DISPATCH_STATS_EN
    logic [15:0] DISP_CNT, TMO_CNT;
`endif
    state_t      STATE_DBG;

    int n_assert = 0;
    int n_fail   = 0;

    intr_dispatch #(.STABLE_CYC(2), .TIMEOUT(4), .CNT_W(8)) dut (
        .CK(CK), .RST_N(RST_N), .PA(PA), .PB(PB), .PC(PC), .CHAN(CHAN),
        .GRP_MASK(GRP_MASK), .INT_REQ(INT_REQ), .INT_VEC(INT_VEC), .INT_ACK(INT_ACK),
        .CLR_VLD(CLR_VLD), .CLR_GRP(CLR_GRP), .CLR_CHAN(CLR_CHAN), .CLR_RDY(CLR_RDY),
        .TMO_ERR(TMO_ERR), .BAD_CHAN(BAD_CHAN), .ERR_CLR(ERR_CLR),
`ifdef INTR_DISPATCH_STATS_EN
        .DISP_CNT(DISP_CNT), .TMO_CNT(TMO_CNT),
`endif
        .STATE_DBG(STATE_DBG)
    );

    always #5 CK = ~CK;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_req"},   16'(INT_REQ),   16'd0);
        chk({tag, "_vec"},   16'(INT_VEC),   16'd0);
        chk({tag, "_clrv"},  16'(CLR_VLD),   16'd0);
        chk({tag, "_clrg"},  16'(CLR_GRP),   16'd0);
        chk({tag, "_clrc"},  16'(CLR_CHAN),  16'd0);
        chk({tag, "_state"}, 16'(STATE_DBG), 16'(ST_IDLE));
    endtask

    // Called in a REQ cycle: ack, check the clear command, accept it, drain HOLD.
    task automatic serve(input string tag, input logic [1:0] grp, input logic [3:0] ch);
        INT_ACK = 1'b1;
        step(1);
        INT_ACK = 1'b0;
        chk({tag, "_req_drop"}, 16'(INT_REQ),  16'd0);
        chk({tag, "_clr_vld"},  16'(CLR_VLD),  16'd1);
        chk({tag, "_clr_grp"},  16'(CLR_GRP),  16'(grp));
        chk({tag, "_clr_chan"}, 16'(CLR_CHAN), 16'(ch));
        CLR_RDY = 1'b1;
        PA = 1'b0; PB = 1'b0; PC = 1'b0;
        step(1);
        CLR_RDY = 1'b0;
        chk({tag, "_clr_drop"}, 16'(CLR_VLD),   16'd0);
        chk({tag, "_hold1"},    16'(STATE_DBG), 16'(ST_HOLD));
        step(1);
        chk({tag, "_hold2"},    16'(STATE_DBG), 16'(ST_HOLD));
        step(1);
        chk({tag, "_idle"},     16'(STATE_DBG), 16'(ST_IDLE));
    endtask

    initial begin
        // Reset state
        step(2);
        chk_idle_outs("rst");
        chk("rst_tmo", 16'(TMO_ERR), 16'd0);
        chk("rst_bad", 16'(BAD_CHAN), 16'd0);
        RST_N = 1'b1;
        step(1);

        // Stable request: applied in cycle 0, INT_REQ first in cycle 3
        PA = 1'b1; CHAN = 4'd5;
        step(1);
        chk("stab_c1_req", 16'(INT_REQ), 16'd0);
        step(1);
        chk("stab_c2_req", 16'(INT_REQ), 16'd0);
        chk("stab_c2_st",  16'(STATE_DBG), 16'(ST_QUAL));
        step(1);
        chk("stab_c3_req", 16'(INT_REQ), 16'd1);
        chk("stab_c3_vec", 16'(INT_VEC), 16'h05);
        INT_ACK = 1'b1;
        step(1);
        INT_ACK = 1'b0;
        chk("stab_clr_vld",  16'(CLR_VLD),  16'd1);
        chk("stab_clr_chan", 16'(CLR_CHAN), 16'd5);
        step(1);
        chk("stab_clr_held", 16'(CLR_VLD),  16'd1);
        CLR_RDY = 1'b1; PA = 1'b0;
        step(1);
        CLR_RDY = 1'b0;
        chk("stab_hold1", 16'(STATE_DBG), 16'(ST_HOLD));
        chk("stab_clr_drop", 16'(CLR_VLD), 16'd0);
        step(1);
        chk("stab_hold2", 16'(STATE_DBG), 16'(ST_HOLD));
        step(1);
        chk_idle_outs("stab_end");

        // Priority with mask
        PA = 1'b1; PB = 1'b1; PC = 1'b1; CHAN = 4'd3; GRP_MASK = 3'b001;
        step(3);
        chk("mask1_vec", 16'(INT_VEC), 16'h13);
        serve("mask1", 2'd1, 4'd3);
        PA = 1'b1; PB = 1'b1; PC = 1'b1; CHAN = 4'd3; GRP_MASK = 3'b011;
        step(3);
        chk("mask3_vec", 16'(INT_VEC), 16'h23);
        serve("mask3", 2'd2, 4'd3);
        GRP_MASK = 3'b000;

        // Glitch filter
        PB = 1'b1;
        for (int i = 0; i < 5; i++) begin
            CHAN = (i % 2 == 0) ? 4'd2 : 4'd4;
            step(1);
            chk("glitch_req", 16'(INT_REQ), 16'd0);
        end
        CHAN = 4'd4;
        step(2);
        chk("glitch_settle_req", 16'(INT_REQ), 16'd0);
        step(1);
        chk("glitch_req_up", 16'(INT_REQ), 16'd1);
        chk("glitch_vec",    16'(INT_VEC), 16'h14);
        serve("glitch", 2'd1, 4'd4);

        // Timeout after 4 REQ cycles
        PA = 1'b1; CHAN = 4'd7;
        step(3);
        chk("tmo_req1", 16'(INT_REQ), 16'd1);
        PA = 1'b0; GRP_MASK = 3'b111;
        step(3);
        chk("tmo_req4",     16'(INT_REQ), 16'd1);
        chk("tmo_req4_vec", 16'(INT_VEC), 16'h07);
        chk("tmo_req4_err", 16'(TMO_ERR), 16'd0);
        step(1);
        chk("tmo_drop", 16'(INT_REQ), 16'd0);
        chk("tmo_err",  16'(TMO_ERR), 16'd1);
        chk("tmo_idle", 16'(STATE_DBG), 16'(ST_IDLE));
        GRP_MASK = 3'b000;
        ERR_CLR = 1'b1;
        step(1);
        ERR_CLR = 1'b0;
        chk("tmo_err_clr", 16'(TMO_ERR), 16'd0);

        // Ack in the timeout cycle wins
        PA = 1'b1; CHAN = 4'd6;
        step(3);
        PA = 1'b0;
        step(3);
        chk("ackto_req4", 16'(INT_REQ), 16'd1);
        serve("ackto", 2'd0, 4'd6);
        chk("ackto_no_err", 16'(TMO_ERR), 16'd0);

        // Bad channel and sticky clear
        PA = 1'b1; CHAN = 4'd12;
        step(2);
        chk("bad_set", 16'(BAD_CHAN), 16'd1);
        step(2);
        chk("bad_no_req", 16'(INT_REQ), 16'd0);
        chk("bad_idle",   16'(STATE_DBG), 16'(ST_IDLE));
        PA = 1'b0; CHAN = 4'd0;
        step(2);
        chk("bad_sticky", 16'(BAD_CHAN), 16'd1);
        ERR_CLR = 1'b1;
        step(1);
        ERR_CLR = 1'b0;
        chk("bad_cleared", 16'(BAD_CHAN), 16'd0);
        PA = 1'b1; CHAN = 4'd9;
        step(1);
        ERR_CLR = 1'b1;
        step(1);
        ERR_CLR = 1'b0;
        chk("bad_set_wins", 16'(BAD_CHAN), 16'd1);
        PA = 1'b0; CHAN = 4'd0;
        step(2);

        // Reset in the middle of CLEAR
        PA = 1'b1; CHAN = 4'd5;
        step(3);
        INT_ACK = 1'b1;
        step(1);
        INT_ACK = 1'b0;
        chk("mid_clr_vld", 16'(CLR_VLD), 16'd1);
        RST_N = 1'b0;
        step(1);
        chk_idle_outs("mid_rst");
        chk("mid_rst_tmo", 16'(TMO_ERR), 16'd0);
        chk("mid_rst_bad", 16'(BAD_CHAN), 16'd0);
`ifdef INTR_DISPATCH_STATS_EN
        chk("mid_rst_disp", DISP_CNT, 16'd0);
        chk("mid_rst_tcnt", TMO_CNT,  16'd0);
`endif
        PA = 1'b0;
        RST_N = 1'b1;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_dispatch.md
Name: intr_dispatch

Overview:
- Sequential dispatcher directly downstream of the 27-channel combinational interrupt priority encoder.
- Registers the encoder's group flags PA/PB/PC and 4-bit channel code, and qualifies them against combinational glitches.
- Presents one interrupt vector to the CPU with a req/ack handshake, then issues a clear command back to the request sources with a valid/ready handshake.

Parameters:
STABLE_CYC, 2, consecutive identical registered samples required before dispatch (1..15)
TIMEOUT, 255, cycles INT_REQ may wait for INT_ACK before abandoning (1..2^CNT_W-1)
CNT_W, 8, width of the timeout counter

Ports:
CK  in  1  clock, rising edge
RST_N  in  1  reset, synchronous, active-low
PA  in  1  group A request flag from the priority encoder
PB  in  1  group B request flag
PC  in  1  group C request flag
CHAN  in  4  encoded channel index 0..8 from the priority encoder
GRP_MASK  in  3  per-group mask, bit0=A, bit1=B, bit2=C; 1 = masked
INT_REQ  out  1  interrupt request to CPU
INT_VEC  out  6  {group[1:0], chan[3:0]}; group A=0, B=1, C=2
INT_ACK  in  1  CPU acknowledge
CLR_VLD  out  1  clear command valid
CLR_GRP  out  2  group to clear
CLR_CHAN  out  4  channel to clear
CLR_RDY  in  1  clear command accepted
TMO_ERR  out  1  sticky: ack timeout occurred
BAD_CHAN  out  1  sticky: CHAN > 8 seen with an active group
ERR_CLR  in  1  clears both sticky flags

Behaviour:
- Reset (RST_N=0 at an edge):
  - State IDLE; input registers, counters and all outputs go to 0.
  - Reset applied mid-handshake drops INT_REQ/CLR_VLD on the next edge.
- Input stage: PA, PB, PC and CHAN are registered every cycle. All decisions use only the registered copies.
- Candidate selection:
  - Highest-priority unmasked active group wins, priority A > B > C; chan = registered CHAN.
  - Candidate valid only if a group is selected and CHAN <= 8.
  - CHAN > 8 with a selected group sets BAD_CHAN, and the candidate is treated as absent.
- FSM states: IDLE, QUAL, REQ, CLEAR, HOLD.
- IDLE:
  - Valid candidate: latch {grp, chan}, cnt=1.
  - Next state is REQ if STABLE_CYC==1, else QUAL.
- QUAL:
  - Candidate equals the latch: cnt+1; when cnt+1 == STABLE_CYC, go to REQ.
  - Candidate differs: relatch, cnt=1.
  - No candidate: return to IDLE.
- Latency: candidate inputs applied in cycle 0 and held give INT_REQ=1 first in cycle STABLE_CYC+1.
- REQ:
  - INT_REQ=1 and INT_VEC={grp, chan}, both stable for the whole state.
  - Timeout counter starts at 0 on entry and increments each cycle.
  - INT_ACK=1: go to CLEAR; INT_REQ is 0 on the next cycle.
  - Counter reaches TIMEOUT without ack: set TMO_ERR, go to IDLE.
  - Ack and timeout in the same cycle: ack wins.
  - GRP_MASK and input changes during REQ are ignored; the request is committed.
- CLEAR:
  - CLR_VLD=1 with CLR_GRP/CLR_CHAN equal to the dispatched vector.
  - Held until CLR_RDY=1 is sampled, then go to HOLD. CLR_VLD=0 next cycle.
- HOLD:
  - Fixed 2 cycles with inputs ignored, so the registered inputs reflect the cleared source; then IDLE.
- INT_ACK outside REQ and CLR_RDY outside CLEAR are ignored.
- INT_VEC/CLR_* read as 0 when not in their respective states.
- Sticky flags: ERR_CLR clears them; a set event in the same cycle as ERR_CLR wins.

Optional Feature:
INTR_DISPATCH_STATS_EN:
- Defined:
  - Adds outputs DISP_CNT[15:0], incremented on each accepted INT_ACK.
  - Adds TMO_CNT[15:0], incremented on each timeout.
  - Both saturate at 0xFFFF and are cleared by reset or ERR_CLR.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - Group encodings GRP_A=2'd0, GRP_B=2'd1, GRP_C=2'd2.
  - MAX_CHAN=4'd8.
  - Vector width constant 6.
- One sub-module: intr_qualify (input register, priority/mask select, BAD_CHAN detect, stability counter), with qualified-valid plus {grp, chan} output to the dispatcher FSM.

Test Plan:
- Stable request: PA=1, CHAN=5, mask 0, STABLE_CYC=2, inputs applied cycle 0 → INT_REQ=1 in cycle 3, INT_VEC=6'b00_0101.
  - Then ack → CLR_VLD=1, CLR_GRP=0, CLR_CHAN=5.
  - CLR_RDY=1 → IDLE after 2 HOLD cycles.
- Priority/mask: PA=PB=PC=1, CHAN=3, GRP_MASK=3'b001 → INT_VEC=6'b01_0011.
  - GRP_MASK=3'b011 → INT_VEC=6'b10_0011.
- Glitch filter: CHAN toggles 2→4→2 each cycle with PB=1 → INT_REQ stays 0.
  - Then CHAN held at 4 → INT_REQ after STABLE_CYC qualifying samples with INT_VEC=6'b01_0100.
- Timeout: TIMEOUT=4, no ack → INT_REQ drops after 4 REQ cycles and TMO_ERR=1.
  - Ack arriving in the timeout cycle → CLEAR entered, TMO_ERR stays 0.
- Bad channel/sticky: PA=1, CHAN=12 → BAD_CHAN=1, no INT_REQ.
  - ERR_CLR pulse → 0; ERR_CLR coincident with a new CHAN=9 event → BAD_CHAN stays 1.
- Reset mid-operation: RST_N=0 while CLR_VLD=1 and CLR_RDY=0 → next edge: all outputs 0, state IDLE.
  - With INTR_DISPATCH_STATS_EN: DISP_CNT=0.
